// File: rtl/sd_block_sched.sv
// sd_block_sched: shares the single host block port between link block reads and writes.
// Optional SD_BLOCK_SCHED_TIMEOUT_EN adds a wait-state watchdog driving sticky err_timeout.
module sd_block_sched #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk_50,
   input  logic             reset_n,
   input  logic             block_read_act,
   input  logic [31:0]      block_read_addr,
   input  logic [31:0]      block_read_num,
   input  logic             block_read_stop,
   output logic             block_read_go,
   input  logic             block_write_act,
   input  logic [31:0]      block_write_addr,
   output logic             block_write_done,
   output logic             host_req,
   output logic             host_we,
   output logic [31:0]      host_addr,
   input  logic             host_ack,
   input  logic             host_done,
   output logic             busy,
   output logic [CNT_W-1:0] blocks_read,
   output logic [CNT_W-1:0] blocks_written,
   output logic             err_timeout,
   output logic [2:0]       dbg_state
);

   // Host port handshake: host_req is held with host_we/host_addr stable until host_ack
   // is sampled high; host_req drops the following cycle, and host_done later pulses once
   // when the block has been moved.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      RD_GO   = 3'd3,
      WR_REQ  = 3'd4,
      WR_WAIT = 3'd5,
      WR_DONE = 3'd6,
      DRAIN   = 3'd7
   } state_t;

   state_t      state;
   logic        rd_act_q;
   logic        wr_act_q;
   logic        pend_rd;
   logic        pend_wr;
   logic [31:0] addr;
   logic [31:0] rem;
   logic        rd_rise;
   logic        wr_rise;
   logic        rd_abort;

   if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
      $error("sd_block_sched: TIMEOUT_CYCLES must be at least 2");
   end

   assign rd_rise   = block_read_act & ~rd_act_q;
   assign wr_rise   = block_write_act & ~wr_act_q;
   assign rd_abort  = block_read_stop | ~block_read_act;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

`ifdef SD_BLOCK_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_eff;
   state_t           tmo_state;
   logic             tmo_run;
   logic             tmo_hit;

   // tmo_eff is the number of cycles already spent in the current state.
   assign tmo_run = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ) ||
                    (state == WR_WAIT) || (state == DRAIN);
   assign tmo_eff = (state != tmo_state) ? '0 : tmo_cnt;
   assign tmo_hit = tmo_run && (tmo_eff == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt   <= '0;
         tmo_state <= IDLE;
      end else begin
         tmo_state <= state;
         tmo_cnt   <= tmo_run ? tmo_eff + TMO_W'(1) : '0;
      end
   end
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         rd_act_q         <= 1'b0;
         wr_act_q         <= 1'b0;
         pend_rd          <= 1'b0;
         pend_wr          <= 1'b0;
         addr             <= '0;
         rem              <= '0;
         host_req         <= 1'b0;
         host_we          <= 1'b0;
         host_addr        <= '0;
         block_read_go    <= 1'b0;
         block_write_done <= 1'b0;
         blocks_read      <= '0;
         blocks_written   <= '0;
`ifdef SD_BLOCK_SCHED_TIMEOUT_EN
         err_timeout      <= 1'b0;
`endif
      end else begin
         rd_act_q         <= block_read_act;
         wr_act_q         <= block_write_act;
         block_read_go    <= 1'b0;
         block_write_done <= 1'b0;
         if (rd_rise) pend_rd <= 1'b1;
         if (wr_rise) pend_wr <= 1'b1;
`ifdef SD_BLOCK_SCHED_TIMEOUT_EN
         if (tmo_hit) begin
            err_timeout <= 1'b1;
            host_req    <= 1'b0;
            pend_rd     <= 1'b0;
            pend_wr     <= 1'b0;
            state       <= IDLE;
         end else
`endif
         begin
            case (state)
               IDLE: begin
                  // Writes go first so the link's single write buffer is freed early.
                  if (pend_wr) begin
                     pend_wr   <= wr_rise;
                     host_req  <= 1'b1;
                     host_we   <= 1'b1;
                     host_addr <= block_write_addr;
                     state     <= WR_REQ;
                  end else if (pend_rd) begin
                     pend_rd   <= rd_rise;
                     addr      <= block_read_addr;
                     rem       <= block_read_num;
                     host_req  <= 1'b1;
                     host_we   <= 1'b0;
                     host_addr <= block_read_addr;
                     state     <= RD_REQ;
                  end
               end
               RD_REQ: begin
                  if (host_ack) begin
                     host_req <= 1'b0;
                     state    <= rd_abort ? DRAIN : RD_WAIT;
                  end else if (rd_abort) begin
                     host_req <= 1'b0;
                     state    <= IDLE;
                  end
               end
               RD_WAIT: begin
                  // An abort coinciding with host_done needs no drain: the block is already over.
                  if (rd_abort) begin
                     state <= host_done ? IDLE : DRAIN;
                  end else if (host_done) begin
                     block_read_go <= 1'b1;
                     blocks_read   <= blocks_read + CNT_W'(1);
                     state         <= RD_GO;
                  end
               end
               RD_GO: begin
                  addr <= addr + 32'd1;
                  if ((rem == 32'd1) || rd_abort) begin
                     state <= IDLE;
                  end else begin
                     if (rem != 32'd0) rem <= rem - 32'd1;
                     host_req  <= 1'b1;
                     host_we   <= 1'b0;
                     host_addr <= addr + 32'd1;
                     state     <= RD_REQ;
                  end
               end
               WR_REQ: begin
                  if (host_ack) begin
                     host_req <= 1'b0;
                     state    <= WR_WAIT;
                  end
               end
               WR_WAIT: begin
                  if (host_done) begin
                     block_write_done <= 1'b1;
                     blocks_written   <= blocks_written + CNT_W'(1);
                     state            <= WR_DONE;
                  end
               end
               WR_DONE: state <= IDLE;
               DRAIN: begin
                  if (host_done) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_block_sched.sv
// tb_sd_block_sched: randomized bench for sd_block_sched against a transaction-level host model.
// Built with CNT_W=4 so counter wrap is reachable; the watchdog case runs only with SD_BLOCK_SCHED_TIMEOUT_EN.
module tb_sd_block_sched;

  localparam int CNT_W = 4;
  localparam int TMO   = 50;

  // clock / reset
  logic clk_50;
  logic reset_n;

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  logic             block_read_act;
  logic [31:0]      block_read_addr;
  logic [31:0]      block_read_num;
  logic             block_read_stop;
  logic             block_read_go;
  logic             block_write_act;
  logic [31:0]      block_write_addr;
  logic             block_write_done;
  logic             host_req;
  logic             host_we;
  logic [31:0]      host_addr;
  logic             host_ack;
  logic             host_done;
  logic             busy;
  logic [CNT_W-1:0] blocks_read;
  logic [CNT_W-1:0] blocks_written;
  logic             err_timeout;
  logic [2:0]       dbg_state;

  sd_block_sched #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50           (clk_50),
    .reset_n          (reset_n),
    .block_read_act   (block_read_act),
    .block_read_addr  (block_read_addr),
    .block_read_num   (block_read_num),
    .block_read_stop  (block_read_stop),
    .block_read_go    (block_read_go),
    .block_write_act  (block_write_act),
    .block_write_addr (block_write_addr),
    .block_write_done (block_write_done),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_ack         (host_ack),
    .host_done        (host_done),
    .busy             (busy),
    .blocks_read      (blocks_read),
    .blocks_written   (blocks_written),
    .err_timeout      (err_timeout),
    .dbg_state        (dbg_state)
  );

  // scoreboard: expected host requests as {we, addr}, plus expected pulse totals
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int go_cnt   = 0;
  int wd_cnt   = 0;
  int exp_go   = 0;
  int exp_wd   = 0;
  int exp_rd_ctr = 0;
  int exp_wr_ctr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_50) begin
    if (block_read_go === 1'b1) go_cnt++;
    if (block_write_done === 1'b1) wd_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // driver tasks: all start and end just after a falling edge
  task automatic host_accept(input int ack_dly);
    int n;
    logic [32:0] want;
    n = 0;
    while (host_req !== 1'b1 && n < 60) begin
      @(negedge clk_50);
      n++;
    end
    check("req_seen", 64'(host_req), 64'(1));
    if (host_req !== 1'b1) return;
    check("exp_q_nonempty", 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() == 0) return;
    want = exp_q.pop_front();
    check("req_we_addr", 64'({host_we, host_addr}), 64'(want));
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk_50);
      check("req_hold", 64'({host_req, host_we, host_addr}), 64'({1'b1, want}));
    end
    host_ack = 1'b1;
    @(negedge clk_50);
    host_ack = 1'b0;
    check("req_drop", 64'(host_req), 64'(0));
  endtask

  task automatic host_finish(input int done_dly);
    repeat (done_dly) @(negedge clk_50);
    host_done = 1'b1;
    @(negedge clk_50);
    host_done = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int num, input int ack_d, input int done_d);
    block_read_addr = a;
    block_read_num  = 32'(num);
    block_read_act  = 1'b1;
    for (int i = 0; i < num; i++) begin
      exp_q.push_back({1'b0, a + 32'(i)});
      host_accept((ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d);
      host_finish((done_d < 0) ? int'($urandom_range(0, 6)) : done_d);
      exp_go++;
      exp_rd_ctr++;
    end
    repeat (2) @(negedge clk_50);
    block_read_act = 1'b0;
    @(negedge clk_50);
    check("rd_go_count", 64'(go_cnt), 64'(exp_go));
    check("rd_counter", 64'(blocks_read), 64'(exp_rd_ctr % 16));
    check("rd_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_write(input logic [31:0] a);
    block_write_addr = a;
    block_write_act  = 1'b1;
    exp_q.push_back({1'b1, a});
    host_accept(int'($urandom_range(0, 3)));
    host_finish(int'($urandom_range(0, 6)));
    exp_wd++;
    exp_wr_ctr++;
    @(negedge clk_50);
    block_write_act = 1'b0;
    @(negedge clk_50);
    check("wr_done_count", 64'(wd_cnt), 64'(exp_wd));
    check("wr_counter", 64'(blocks_written), 64'(exp_wr_ctr % 16));
    check("wr_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    reset_n          = 1'b0;
    block_read_act   = 1'b0;
    block_read_addr  = '0;
    block_read_num   = '0;
    block_read_stop  = 1'b0;
    block_write_act  = 1'b0;
    block_write_addr = '0;
    host_ack         = 1'b0;
    host_done        = 1'b0;
    repeat (3) @(negedge clk_50);
    check("reset_outputs", 64'({host_req, host_we, host_addr, block_read_go, block_write_done,
                                busy, blocks_read, blocks_written, err_timeout}), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);

    // three-block read, fixed host latency
    do_read(32'h100, 3, 2, 10);

    // open-ended read stopped while waiting on an accepted block
    block_read_addr = 32'h20;
    block_read_num  = 32'd0;
    block_read_act  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 32'h20 + 32'(i)});
      host_accept(int'($urandom_range(0, 3)));
      host_finish(int'($urandom_range(0, 6)));
      exp_go++;
      exp_rd_ctr++;
    end
    exp_q.push_back({1'b0, 32'h22});
    host_accept(1);
    block_read_stop = 1'b1;
    repeat (3) @(negedge clk_50);
    check("drain_no_go", 64'(go_cnt), 64'(exp_go));
    check("drain_req_low", 64'(host_req), 64'(0));
    check("drain_busy", 64'(busy), 64'(1));
    host_done = 1'b1;
    @(negedge clk_50);
    host_done = 1'b0;
    @(negedge clk_50);
    check("drain_idle", 64'(busy), 64'(0));
    check("drain_go_after", 64'(go_cnt), 64'(exp_go));
    check("drain_counter", 64'(blocks_read), 64'(exp_rd_ctr % 16));
    block_read_stop = 1'b0;
    block_read_act  = 1'b0;
    repeat (2) @(negedge clk_50);

    // stop and host_done in the same wait cycle: no go pulse, straight to idle
    block_read_addr = 32'h30;
    block_read_num  = 32'd2;
    block_read_act  = 1'b1;
    exp_q.push_back({1'b0, 32'h30});
    host_accept(0);
    @(negedge clk_50);
    host_done       = 1'b1;
    block_read_stop = 1'b1;
    @(negedge clk_50);
    host_done = 1'b0;
    @(negedge clk_50);
    check("stop_done_no_go", 64'(go_cnt), 64'(exp_go));
    check("stop_done_idle", 64'(busy), 64'(0));
    block_read_stop = 1'b0;
    block_read_act  = 1'b0;
    repeat (2) @(negedge clk_50);

    // read and write rising together: write served first
    block_write_addr = 32'h55;
    block_read_addr  = 32'h10;
    block_read_num   = 32'd1;
    exp_q.push_back({1'b1, 32'h55});
    exp_q.push_back({1'b0, 32'h10});
    block_write_act = 1'b1;
    block_read_act  = 1'b1;
    host_accept(int'($urandom_range(0, 3)));
    host_finish(int'($urandom_range(0, 6)));
    exp_wd++;
    exp_wr_ctr++;
    host_accept(int'($urandom_range(0, 3)));
    check("wr_before_rd", 64'(wd_cnt), 64'(exp_wd));
    host_finish(int'($urandom_range(0, 6)));
    exp_go++;
    exp_rd_ctr++;
    repeat (2) @(negedge clk_50);
    block_write_act = 1'b0;
    block_read_act  = 1'b0;
    @(negedge clk_50);
    check("both_go", 64'(go_cnt), 64'(exp_go));
    check("both_wr_counter", 64'(blocks_written), 64'(exp_wr_ctr % 16));
    check("both_rd_counter", 64'(blocks_read), 64'(exp_rd_ctr % 16));

    // asynchronous reset while waiting on a read block
    block_read_addr = 32'h40;
    block_read_num  = 32'd1;
    block_read_act  = 1'b1;
    exp_q.push_back({1'b0, 32'h40});
    host_accept(1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({host_req, host_we, host_addr, block_read_go, block_write_done,
                                      busy, blocks_read, blocks_written, err_timeout}), 64'(0));
    exp_rd_ctr = 0;
    exp_wr_ctr = 0;
    block_read_act = 1'b0;
    @(negedge clk_50);
    reset_n = 1'b1;
    @(negedge clk_50);
    host_done = 1'b1;
    @(negedge clk_50);
    host_done = 1'b0;
    repeat (3) @(negedge clk_50);
    check("reset_no_go", 64'(go_cnt), 64'(exp_go));
    check("reset_idle", 64'(busy), 64'(0));

    // 17 single-block reads wrap the 4-bit counter
    for (int i = 0; i < 17; i++) do_read($urandom, 1, -1, -1);
    check("wrap_counter", 64'(blocks_read), 64'(exp_rd_ctr % 16));

    // random mix of writes and multi-block reads
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom);
      else do_read($urandom, int'($urandom_range(1, 4)), -1, -1);
    end

    // host_done while idle is ignored
    host_done = 1'b1;
    @(negedge clk_50);
    host_done = 1'b0;
    repeat (3) @(negedge clk_50);
    check("idle_done_busy", 64'(busy), 64'(0));
    check("idle_done_pulses", 64'({go_cnt[15:0], wd_cnt[15:0]}), 64'({exp_go[15:0], exp_wd[15:0]}));

    // stop while idle or during a write is ignored and not remembered
    block_read_stop = 1'b1;
    repeat (3) @(negedge clk_50);
    do_write($urandom);
    block_read_stop = 1'b0;
    @(negedge clk_50);
    do_read($urandom, 2, -1, -1);

`ifdef SD_BLOCK_SCHED_TIMEOUT_EN
    // host never acks: watchdog fires after TMO cycles in RD_REQ
    block_read_addr = 32'h77;
    block_read_num  = 32'd1;
    block_read_act  = 1'b1;
    n = 0;
    while (host_req !== 1'b1 && n < 20) begin
      @(negedge clk_50);
      n++;
    end
    check("tmo_req_seen", 64'(host_req), 64'(1));
    n = 0;
    while (err_timeout !== 1'b1 && n < TMO + 10) begin
      @(negedge clk_50);
      n++;
    end
    check("tmo_cycle", 64'(n), 64'(TMO));
    check("tmo_req_low", 64'(host_req), 64'(0));
    check("tmo_idle", 64'(busy), 64'(0));
    block_read_act = 1'b0;
    repeat (5) @(negedge clk_50);
    check("tmo_sticky", 64'(err_timeout), 64'(1));
    check("tmo_no_go", 64'(go_cnt), 64'(exp_go));
`else
    n = 0;
    check("err_timeout_low", 64'(err_timeout), 64'(0));
`endif

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_block_sched.md
Name: sd_block_sched

Overview:
- Block-transfer scheduler between the SD link layer's block interface and the host-side memory mover.
- Owns the single host port and shares it between link block-read and block-write requests.
- Sequences a per-block req/ack/done handshake and advances the block address.
- Returns block_read_go / block_write_done to the link layer; runs in the clk_50 domain alongside the link layer.

Parameters:
- CNT_W, 16, width of the blocks_read / blocks_written statistics counters.
- TIMEOUT_CYCLES, 1000000, clk_50 cycles allowed in any wait state before abort (used only with the optional feature).

Ports:
- clk_50  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- block_read_act  in  1  link requests a read sequence (level).
- block_read_addr  in  32  first block address, sampled on act rise.
- block_read_num  in  32  block count; 0 = open-ended until stop.
- block_read_stop  in  1  abort the read sequence (level).
- block_read_go  out  1  one-cycle pulse: read buffer filled, link may send.
- block_write_act  in  1  one rising edge per received block ready in the write buffer.
- block_write_addr  in  32  block address for this write.
- block_write_done  out  1  one-cycle pulse: host consumed the write buffer.
- host_req  out  1  host transfer request.
- host_we  out  1  1 = write to backing store, 0 = read from it.
- host_addr  out  32  block address of the current request.
- host_ack  in  1  host accepted the request.
- host_done  in  1  one-cycle pulse: host finished the block.
- busy  out  1  state != IDLE.
- blocks_read  out  CNT_W  go pulses issued, wraps.
- blocks_written  out  CNT_W  done pulses issued, wraps.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset: every output is 0, state = IDLE, pending flags cleared, counters 0. Reset mid-transfer abandons it immediately, with no further pulses.
- Edge detect: registered copies of both act inputs. A rise sets pend_rd or pend_wr. Each pending flag clears when its request is dispatched.
- IDLE dispatch:
  - pend_wr has priority over pend_rd, because the write buffer must be freed first.
  - If both rise in the same cycle, the write is served first; the read is serviced on return to IDLE.
  - Read dispatch latches addr and rem = block_read_num; write dispatch latches block_write_addr.
- RD_REQ:
  - host_req=1, host_we=0, host_addr=addr; all held stable until host_ack is sampled high.
  - host_req drops the cycle after ack; then go to RD_WAIT.
- RD_WAIT: on host_done go to RD_GO.
- RD_GO:
  - block_read_go=1 for exactly one cycle; addr <= addr+1 (32-bit wrap); blocks_read increments.
  - rem==1 goes to IDLE. Otherwise rem decrements (unless 0, i.e. open-ended) and the next state is RD_REQ.
  - First go pulse occurs no earlier than 3 cycles after the act rise.
- Read abort (block_read_stop=1 or block_read_act=0):
  - In RD_REQ before ack: drop req the next cycle, go to IDLE.
  - After ack: go to DRAIN; wait for host_done, then go to IDLE with no go pulse.
  - Stop and host_done in the same RD_WAIT cycle: abort wins and no go pulse is issued.
- WR_REQ: as RD_REQ with host_we=1; then WR_WAIT.
- WR_WAIT: on host_done go to WR_DONE.
- WR_DONE: block_write_done pulse for one cycle, blocks_written increments, go to IDLE. Writes are not aborted by read_stop.
- Late stop: block_read_stop asserted while idle or during a write is ignored and is not latched.
- host_done outside a wait state is ignored.

Optional Feature:
- Macro: SD_BLOCK_SCHED_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on every state change and runs in RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DRAIN.
  - Reaching TIMEOUT_CYCLES sets err_timeout (sticky until reset), drops host_req, clears pending flags and returns to IDLE with no go/done pulse.
- Disabled: no counter; err_timeout is tied 0; wait states may hang indefinitely.

Test Plan:
- Read num=3, addr=0x100; host acks after 2 cycles, done after 10 -> host_addr 0x100/0x101/0x102, exactly 3 go pulses, blocks_read=3, then IDLE.
- Read num=0, addr=0x20; stop after the 2nd go while in RD_WAIT (acked) -> DRAIN, no 3rd go, host_req low, IDLE after done.
- Read and write acts rise in the same cycle (wr addr 0x55, rd addr 0x10, num=1) -> host_we=1 with addr 0x55 first, done pulse, then the read at 0x10, then go.
- Reset asserted in RD_WAIT -> all outputs 0 asynchronously; a later host_done produces no go.
- With SD_BLOCK_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50, host never acks -> err_timeout=1 at cycle 50 of RD_REQ, req drops, state IDLE, flag stays set.
- Counter wrap with CNT_W=4: 17 single-block reads -> blocks_read=1.
